// File: rtl/rx_interface.sv
// Bit-level receive handshake between the sequence decoder and the frame decoder.
// Ports: soc/eoc/error/data_valid are single-cycle strobes; data holds the last data bit.
// Modports: out_bit for the producer, in_bit for the consumer.
interface rx_interface;
  logic soc;
  logic eoc;
  logic error;
  logic data_valid;
  logic data;

  modport out_bit (output soc, eoc, error, data_valid, data);
  modport in_bit  (input  soc, eoc, error, data_valid, data);
endinterface

// File: rtl/sequence_decode_multirate.sv
// Modified-Miller decoder: pause timing -> X/Y/Z sequences -> soc/eoc/data/error strobes,
// at a runtime-selectable bit rate (ETU = BASE_ETU >> sel) latched while idle.
// Ports: clk, rst_n (async, active-low), pause_n_synchronised, bit_rate_sel[1:0] in;
//        active_rate[1:0], idle, out_iface (rx_interface.out_bit) out. Outputs lag one sequence.
module sequence_decode_multirate #(
  parameter int unsigned BASE_ETU     = 128,
  parameter int unsigned MAX_RATE_SEL = 3,
  parameter int unsigned CNT_W        = $clog2(3*BASE_ETU+1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pause_n_synchronised,
  input  logic [1:0]   bit_rate_sel,
  output logic [1:0]   active_rate,
  output logic         idle,
  rx_interface.out_bit out_iface
);

  typedef enum logic [1:0] {
    SEQ_X   = 2'd0,
    SEQ_Y   = 2'd1,
    SEQ_Z   = 2'd2,
    SEQ_ERR = 2'd3
  } seq_e;

  localparam logic [1:0]       MAX_SEL  = 2'(MAX_RATE_SEL);
  localparam logic [CNT_W-1:0] ETU_BASE = CNT_W'(BASE_ETU);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  // State
  logic             pause_n_last_q;
  logic             idle_q, idle_d;
  logic [1:0]       active_rate_q, active_rate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  seq_e             seq_prev_q, seq_prev_d;
  logic             prev_is_soc_q, prev_is_soc_d;
  logic             in_frame_q, in_frame_d;
  logic             soc_q, soc_d;
  logic             eoc_q, eoc_d;
  logic             error_q, error_d;
  logic             data_valid_q, data_valid_d;
  logic             data_q, data_d;

  // Decode-stage results
  logic             pause;
  seq_e             seq;
  logic             seq_vld;
  logic             soc_flag;

  // Rate-dependent thresholds: a constant shifted by the latched rate, so each
  // compare reduces to a small mux of constants.
  logic [CNT_W-1:0] etu, half, margin, timeout;

  always_comb begin
    etu    = ETU_BASE >> active_rate_q;
    half   = etu >> 1;
    margin = etu >> 5;
    case (seq_prev_q)
      SEQ_X:   timeout = etu + margin;
      SEQ_Z:   timeout = etu + half + margin;
      SEQ_Y:   timeout = etu;
      default: timeout = (etu << 1) + etu;
    endcase
  end

  // End of a pause is the rising edge of pause_n.
  assign pause = pause_n_synchronised & ~pause_n_last_q;

  // Sequence decode
  always_comb begin
    idle_d        = idle_q;
    active_rate_d = active_rate_q;
    cnt_d         = cnt_q;
    seq           = seq_prev_q;
    seq_vld       = 1'b0;
    soc_flag      = 1'b0;

    if (idle_q) begin
      active_rate_d = (bit_rate_sel > MAX_SEL) ? MAX_SEL : bit_rate_sel;
      if (pause) begin
        seq      = SEQ_Z;
        seq_vld  = 1'b1;
        soc_flag = 1'b1;
        idle_d   = 1'b0;
        cnt_d    = ONE;
      end
    end else begin
      cnt_d = cnt_q + ONE;
      if (pause) begin
        // Pause takes priority over a timeout landing on the same cycle.
        cnt_d   = ONE;
        // Once in ERROR, further pauses are swallowed until the long timeout.
        seq_vld = (seq_prev_q != SEQ_ERR);
        case (seq_prev_q)
          SEQ_X:   seq = (cnt_q <= half + margin) ? SEQ_ERR : SEQ_X;
          SEQ_Z: begin
            if (cnt_q <= half + margin)           seq = SEQ_ERR;
            else if (cnt_q <= etu + margin - ONE) seq = SEQ_Z;
            else                                  seq = SEQ_X;
          end
          SEQ_Y:   seq = (cnt_q <= half) ? SEQ_Z : SEQ_X;
          default: seq = SEQ_ERR;
        endcase
      end else if (cnt_q == timeout) begin
        seq     = SEQ_Y;
        seq_vld = 1'b1;
        cnt_d   = ONE;
        // Two Y in a row means the line has gone quiet: end of traffic.
        if (seq_prev_q == SEQ_Y) idle_d = 1'b1;
      end
    end
  end

  // Output stage: each sequence is classified once the next one arrives.
  always_comb begin
    seq_prev_d    = seq_prev_q;
    prev_is_soc_d = prev_is_soc_q;
    in_frame_d    = in_frame_q;
    soc_d         = 1'b0;
    eoc_d         = 1'b0;
    error_d       = 1'b0;
    data_valid_d  = 1'b0;
    data_d        = data_q;

    if (seq_vld) begin
      seq_prev_d    = seq;
      prev_is_soc_d = soc_flag;
      if (soc_flag) begin
        // The SOC Z itself produces nothing; it is reported with the next sequence.
      end else if (prev_is_soc_q) begin
        soc_d      = 1'b1;
        in_frame_d = 1'b1;
      end else if (in_frame_q) begin
        if ((seq_prev_q == SEQ_Y || seq_prev_q == SEQ_Z) && seq == SEQ_Y) begin
          eoc_d      = 1'b1;
          in_frame_d = 1'b0;
        end else if (seq_prev_q == SEQ_ERR) begin
          error_d = 1'b1;
        end else begin
          data_valid_d = 1'b1;
          data_d       = (seq_prev_q == SEQ_X);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_n_last_q <= 1'b1;
      idle_q         <= 1'b1;
      active_rate_q  <= 2'd0;
      cnt_q          <= '0;
      seq_prev_q     <= SEQ_Y;
      prev_is_soc_q  <= 1'b0;
      in_frame_q     <= 1'b0;
      soc_q          <= 1'b0;
      eoc_q          <= 1'b0;
      error_q        <= 1'b0;
      data_valid_q   <= 1'b0;
      data_q         <= 1'b0;
    end else begin
      pause_n_last_q <= pause_n_synchronised;
      idle_q         <= idle_d;
      active_rate_q  <= active_rate_d;
      cnt_q          <= cnt_d;
      seq_prev_q     <= seq_prev_d;
      prev_is_soc_q  <= prev_is_soc_d;
      in_frame_q     <= in_frame_d;
      soc_q          <= soc_d;
      eoc_q          <= eoc_d;
      error_q        <= error_d;
      data_valid_q   <= data_valid_d;
      data_q         <= data_d;
    end
  end

  assign active_rate          = active_rate_q;
  assign idle                 = idle_q;
  assign out_iface.soc        = soc_q;
  assign out_iface.eoc        = eoc_q;
  assign out_iface.error      = error_q;
  assign out_iface.data_valid = data_valid_q;
  assign out_iface.data       = data_q;

endmodule

// File: tb/tb_sequence_decode_multirate.sv
// Directed bench for sequence_decode_multirate: frames at several rates, error path,
// rate latching, rate clamping and asynchronous reset mid-frame.
// Event outputs are compared as {soc, eoc, error, data_valid, data}.
module tb_sequence_decode_multirate;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pause_n;
  logic [1:0] sel;
  logic [1:0] ar0, ar1;
  logic       idle0, idle1;

  always #5 clk = ~clk;

  rx_interface if0 ();
  rx_interface if1 ();

  sequence_decode_multirate #(.BASE_ETU(128), .MAX_RATE_SEL(3)) dut0 (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pause_n_synchronised (pause_n),
    .bit_rate_sel         (sel),
    .active_rate          (ar0),
    .idle                 (idle0),
    .out_iface            (if0)
  );

  sequence_decode_multirate #(.BASE_ETU(128), .MAX_RATE_SEL(1)) dut1 (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pause_n_synchronised (pause_n),
    .bit_rate_sel         (sel),
    .active_rate          (ar1),
    .idle                 (idle1),
    .out_iface            (if1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int stray    = 0;

  logic [4:0] obs;
  logic [4:0] obs1;
  assign obs  = {if0.soc, if0.eoc, if0.error, if0.data_valid, if0.data};
  assign obs1 = {if1.soc, if1.eoc, if1.error, if1.data_valid, if1.data};

  // Advance 'gap' clock edges from the previous event edge. With is_pause the last
  // of those edges sees the rising edge of pause_n; otherwise it is a quiet wait.
  // Strobes seen on any edge before the last are tallied in 'stray'.
  task automatic step(input bit is_pause, input int gap);
    for (int i = 1; i <= gap; i++) begin
      @(posedge clk);
      #1;
      if (i < gap && (if0.soc | if0.eoc | if0.error | if0.data_valid)) stray++;
      if (is_pause && i == gap - 2) pause_n = 1'b0;
      if (is_pause && i == gap - 1) pause_n = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    pause_n = 1'b1;
    sel     = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL reset_out: got %b expected 00000", obs); end
    n_checks++;
    if (idle0 !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle0); end
    n_checks++;
    if (ar0 !== 2'd0) begin n_fail++; $display("FAIL reset_rate: got %0d expected 0", ar0); end
    n_checks++;
    if (obs1 !== 5'b00000 || idle1 !== 1'b1) begin
      n_fail++; $display("FAIL reset_dut1: got out=%b idle=%b expected 00000/1", obs1, idle1);
    end
    rst_n = 1'b1;
    step(1'b0, 2);
  endtask

  task automatic test_rate_clamp();
    sel = 2'd3;
    step(1'b0, 3);
    n_checks++;
    if (ar0 !== 2'd3) begin n_fail++; $display("FAIL clamp_max3: got %0d expected 3", ar0); end
    n_checks++;
    if (ar1 !== 2'd1) begin n_fail++; $display("FAIL clamp_max1: got %0d expected 1", ar1); end
  endtask

  task automatic test_rate3();
    bit         pz[6]  = '{1, 1, 0, 1, 0, 0};
    int         gap[6] = '{5, 24, 16, 8, 24, 16};
    logic [4:0] ex[6]  = '{5'b00000, 5'b10000, 5'b00011, 5'b00010, 5'b01000, 5'b00000};
    sel   = 2'd3;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      step(pz[i], gap[i]);
      n_checks++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL rate3_ev%0d: got %b expected %b", i, obs, ex[i]); end
    end
    n_checks++;
    if (ar0 !== 2'd3) begin n_fail++; $display("FAIL rate3_active: got %0d expected 3", ar0); end
    n_checks++;
    if (idle0 !== 1'b1) begin n_fail++; $display("FAIL rate3_idle: got %b expected 1", idle0); end
    n_checks++;
    if (stray !== 0) begin n_fail++; $display("FAIL rate3_stray: got %0d expected 0", stray); end
  endtask

  task automatic test_rate0_basic();
    bit         pz[6]  = '{1, 1, 0, 1, 0, 0};
    int         gap[6] = '{5, 192, 132, 60, 196, 128};
    logic [4:0] ex[6]  = '{5'b00000, 5'b10000, 5'b00011, 5'b00010, 5'b01000, 5'b00000};
    sel   = 2'd0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      step(pz[i], gap[i]);
      n_checks++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL basic_ev%0d: got %b expected %b", i, obs, ex[i]); end
      if (i == 2) begin
        n_checks++;
        if (idle0 !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b expected 0", idle0); end
      end
    end
    n_checks++;
    if (ar0 !== 2'd0) begin n_fail++; $display("FAIL basic_active: got %0d expected 0", ar0); end
    n_checks++;
    if (idle0 !== 1'b1) begin n_fail++; $display("FAIL basic_idle: got %b expected 1", idle0); end
    n_checks++;
    if (stray !== 0) begin n_fail++; $display("FAIL basic_stray: got %0d expected 0", stray); end
  endtask

  task automatic test_error();
    bit         pz[6]  = '{1, 1, 1, 0, 0, 0};
    int         gap[6] = '{5, 40, 100, 384, 128, 128};
    logic [4:0] ex[6]  = '{5'b00000, 5'b10000, 5'b00000, 5'b00100, 5'b01000, 5'b00000};
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      step(pz[i], gap[i]);
      n_checks++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL error_ev%0d: got %b expected %b", i, obs, ex[i]); end
    end
    n_checks++;
    if (idle0 !== 1'b1) begin n_fail++; $display("FAIL error_idle: got %b expected 1", idle0); end
    n_checks++;
    if (stray !== 0) begin n_fail++; $display("FAIL error_stray: got %0d expected 0", stray); end
  endtask

  task automatic test_rate_change();
    bit         pz[6]  = '{1, 1, 0, 1, 0, 0};
    int         ga[6]  = '{5, 192, 132, 60, 196, 128};
    int         gb[6]  = '{5, 48, 33, 15, 49, 32};
    logic [4:0] ex[6]  = '{5'b00000, 5'b10000, 5'b00011, 5'b00010, 5'b01000, 5'b00000};
    sel   = 2'd0;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      step(pz[i], ga[i]);
      if (i == 1) sel = 2'd2;
      n_checks++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL chg_a_ev%0d: got %b expected %b", i, obs, ex[i]); end
      if (i == 3) begin
        n_checks++;
        if (ar0 !== 2'd0) begin n_fail++; $display("FAIL chg_hold: got %0d expected 0", ar0); end
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(pz[i], gb[i]);
      n_checks++;
      if (obs !== ex[i]) begin n_fail++; $display("FAIL chg_b_ev%0d: got %b expected %b", i, obs, ex[i]); end
    end
    n_checks++;
    if (ar0 !== 2'd2) begin n_fail++; $display("FAIL chg_new: got %0d expected 2", ar0); end
    n_checks++;
    if (idle0 !== 1'b1 || stray !== 0) begin
      n_fail++; $display("FAIL chg_end: got idle=%b stray=%0d expected 1/0", idle0, stray);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit         pa[5]  = '{1, 1, 0, 1, 1};
    int         ga[5]  = '{5, 192, 132, 100, 130};
    logic [4:0] ea[5]  = '{5'b00000, 5'b10000, 5'b00011, 5'b00010, 5'b00011};
    bit         pb[6]  = '{1, 1, 0, 1, 0, 0};
    int         gb[6]  = '{5, 192, 132, 60, 196, 128};
    logic [4:0] eb[6]  = '{5'b00000, 5'b10000, 5'b00011, 5'b00010, 5'b01000, 5'b00000};
    sel   = 2'd0;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      step(pa[i], ga[i]);
      n_checks++;
      if (obs !== ea[i]) begin n_fail++; $display("FAIL rst_a_ev%0d: got %b expected %b", i, obs, ea[i]); end
    end
    // Assert reset between clock edges while the data strobe is still high.
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL rst_mid_out: got %b expected 00000", obs); end
    n_checks++;
    if (idle0 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_idle: got %b expected 1", idle0); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(pb[i], gb[i]);
      n_checks++;
      if (obs !== eb[i]) begin n_fail++; $display("FAIL rst_b_ev%0d: got %b expected %b", i, obs, eb[i]); end
    end
    n_checks++;
    if (idle0 !== 1'b1 || stray !== 0) begin
      n_fail++; $display("FAIL rst_end: got idle=%b stray=%0d expected 1/0", idle0, stray);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    pause_n = 1'b1;
    sel     = 2'd0;
    test_reset();
    test_rate_clamp();
    test_rate3();
    test_rate0_basic();
    test_error();
    test_rate_change();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
